// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: stall/flush controls for the 5-stage core, covering
// load-use, taken branch, dmem wait with timeout and HLT drain.
module hazard_stall_ctrl #(
  parameter int unsigned REG_BITS    = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                ex_memread,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                branch_taken,
  input  logic                halt_id,
  input  logic                dmem_req,
  input  logic                dmem_ready,
  output logic                pc_wen,
  output logic                ifid_stall,
  output logic                idex_stall,
  output logic                exmem_stall,
  output logic                ifid_flush,
  output logic                idex_flush,
  output logic                memwb_flush,
  output logic                halted,
  output logic                mem_err,
  output logic [CNT_W-1:0]    stall_cycles
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] DRAIN    = 2'd2;
  localparam logic [1:0] HALTED   = 2'd3;

  localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);

  logic [1:0]      state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_nxt;
  logic [1:0]      drain_cnt, drain_nxt;
  logic            mem_wait, load_use, timeout;

  assign mem_wait = dmem_req & ~dmem_ready;
  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((id_uses_rs && (id_rs == ex_rd)) ||
                     (id_uses_rt && (id_rt == ex_rd)));
  assign timeout  = mem_wait && (state != HALTED) &&
                    (wait_cnt == WC_W'(MEM_TIMEOUT - 1));

  always_comb begin
    pc_wen      = 1'b1;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    drain_nxt   = drain_cnt;

    case (state)
      RUN, MEM_WAIT: begin
        if (mem_wait) begin
          pc_wen      = 1'b0;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_stall = 1'b1;
          memwb_flush = 1'b1;
          wait_nxt    = wait_cnt + 1'b1;
          state_nxt   = timeout ? HALTED : MEM_WAIT;
        end else begin
          wait_nxt  = '0;
          state_nxt = RUN;
          // The release cycle out of MEM_WAIT takes plain defaults.
          if (state == RUN) begin
            if (load_use) begin
              pc_wen     = 1'b0;
              ifid_stall = 1'b1;
              idex_flush = 1'b1;
            end else if (halt_id) begin
              pc_wen     = 1'b0;
              ifid_flush = 1'b1;
              state_nxt  = DRAIN;
              drain_nxt  = '0;
            end else if (branch_taken) begin
              ifid_flush = 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        pc_wen     = 1'b0;
        ifid_flush = 1'b1;
        if (mem_wait) begin
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_stall = 1'b1;
          memwb_flush = 1'b1;
          wait_nxt    = wait_cnt + 1'b1;
          if (timeout) state_nxt = HALTED;
        end else begin
          wait_nxt = '0;
          if (drain_cnt == 2'd2) state_nxt = HALTED;
          else                   drain_nxt = drain_cnt + 1'b1;
        end
      end
      HALTED: begin
        pc_wen      = 1'b0;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
      end
      default: state_nxt = RUN;
    endcase

    if (!rst) begin
      pc_wen      = 1'b0;
      ifid_stall  = 1'b0;
      idex_stall  = 1'b0;
      exmem_stall = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= RUN;
      wait_cnt     <= '0;
      drain_cnt    <= '0;
      halted       <= 1'b0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      drain_cnt <= drain_nxt;
      if ((state != HALTED) && (state_nxt == HALTED)) halted <= 1'b1;
      if (timeout) mem_err <= 1'b1;
      if (!pc_wen && (state != HALTED) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Generates the per-register stall (hold) and flush (bubble) controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC write enable.
- Handles load-use hazards, taken branches, multi-cycle data-memory waits with a timeout, and HLT drain.
- Keeps a saturating stall-cycle performance counter.

Parameters:
REG_BITS, 4, register-specifier width
MEM_TIMEOUT, 15, max consecutive dmem wait cycles before error
CNT_W, 16, stall-cycle counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset: synchronous, active-low
id_rs  in  REG_BITS  ID source reg 1
id_rt  in  REG_BITS  ID source reg 2
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_memread  in  1  EX instruction is a load
ex_rd  in  REG_BITS  EX destination reg
branch_taken  in  1  branch resolved taken in ID
halt_id  in  1  HLT decoded in ID
dmem_req  in  1  MEM stage has an active data access
dmem_ready  in  1  data memory completes this cycle
pc_wen  out  1  PC write enable
ifid_stall, idex_stall, exmem_stall  out  1 each  hold register
ifid_flush, idex_flush, memwb_flush  out  1 each  load bubble (zero control)
halted  out  1  core halted (sticky)
mem_err  out  1  dmem timeout (sticky)
stall_cycles  out  CNT_W  count of cycles with pc_wen=0 while not halted

Behaviour:
- States: RUN, MEM_WAIT, DRAIN, HALTED. FSM and counters update on the rising edge.
- Stall and flush outputs are combinational from state and inputs, so they act in the same cycle.
- Reset (rst=0 at a clock edge):
  - state=RUN, wait_cnt=0, drain_cnt=0, mem_err=0, halted=0, stall_cycles=0.
  - While rst=0: pc_wen=0, all stalls 0, all flushes 1.
- Defaults (RUN, no event): pc_wen=1, all stalls 0, all flushes 0.
- Event priority, highest first: mem wait > load-use > halt > branch. Only the highest-priority event acts in a cycle.
- Mem wait: dmem_req=1 and dmem_ready=0 in RUN or MEM_WAIT.
  - Outputs: pc_wen=0, ifid_stall=idex_stall=exmem_stall=1, memwb_flush=1.
  - Transition: RUN->MEM_WAIT; wait_cnt increments each wait cycle.
  - dmem_ready=1 -> release the same cycle (defaults), MEM_WAIT->RUN, wait_cnt=0.
  - Zero-wait access (ready with req) never stalls.
- Timeout: if a wait cycle occurs with wait_cnt==MEM_TIMEOUT-1, then next state=HALTED, mem_err=1, halted=1.
- Load-use, RUN only: ex_memread=1, ex_rd!=0, and (id_uses_rs and id_rs==ex_rd, or id_uses_rt and id_rt==ex_rd).
  - Outputs: pc_wen=0, ifid_stall=1, idex_flush=1.
  - Lasts exactly one cycle, with no state change: next cycle the load is in MEM and the compare clears.
  - ex_rd==0 never stalls.
- Halt, RUN, no higher event: pc_wen=0, ifid_flush=1, ->DRAIN, drain_cnt=0.
- DRAIN:
  - pc_wen=0, ifid_flush=1.
  - Mem wait inside DRAIN applies the mem-wait outputs and freezes drain_cnt; timeout applies as above.
  - Otherwise drain_cnt increments; when drain_cnt==2 (third non-waiting drain cycle) ->HALTED, halted=1.
- Branch, RUN, no higher event: ifid_flush=1, pc_wen=1. A branch during a load-use stall is ignored; the instruction remains in ID and is re-evaluated next cycle.
- HALTED: pc_wen=0, all stalls 1, all flushes 0. Only reset exits.
- stall_cycles: +1 on each clock edge with rst=1, pc_wen=0 and state!=HALTED; saturates at all-ones.

Test Plan:
- Reset: rst=0 for 2 cycles -> pc_wen=0, ifid_flush=idex_flush=memwb_flush=1. After rst=1: pc_wen=1, all others 0, stall_cycles=0.
- Load-use: ex_memread=1, ex_rd=5, id_uses_rt=1, id_rt=5 -> exactly one cycle of pc_wen=0, ifid_stall=1, idex_flush=1, stall_cycles=1. Same with ex_rd=0 -> no stall.
- Mem wait plus simultaneous hazards: dmem_req=1, ready low for 3 cycles, with a load-use match and branch_taken=1 held -> 3 cycles of mem-wait outputs only, no idex_flush, no ifid_flush. The cycle ready=1 -> defaults.
- Timeout: dmem_req=1, dmem_ready=0 held for 15 cycles -> mem_err=1 and halted=1 after the 15th edge; all stalls=1 thereafter, until reset clears them.
- Halt: halt_id=1 for one cycle in RUN -> 4 cycles with pc_wen=0 and ifid_flush=1 (the halt cycle plus 3 DRAIN cycles), then halted=1. A 2-cycle wait injected mid-drain -> halted asserts 2 cycles later.
- Saturation with CNT_W=4: 20 load-use stall cycles -> stall_cycles=15.
